seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_scanner_if.sv | 32 +++
 rtl/seven_seg_scanner.sv | 91 +++++++++
 tb/tb_seven_seg_scanner.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seven_seg_scanner_if : code-word input and multiplexed display outputs     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface seven_seg_scanner_if;
  logic [15:0] Digit_in;
  logic [3:0]  dp_in;
  logic        en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output Digit_in,
    output dp_in,
    output en,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  Digit_in,
    input  dp_in,
    input  en,
    output an,
    output seg,
    output dp
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seven_seg_scanner : 4-digit common-anode 7-segment scanner with blanking   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 131072,
  parameter int BLANK_CYCLES = 1024
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  seven_seg_scanner_if.slave    bus
);

  localparam int                c_cnt_w    = $clog2(REFRESH_DIV);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_blank    = c_cnt_w'(BLANK_CYCLES);

  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_slot;
  logic [15:0]        r_frame;
  logic [3:0]         r_dp_frame;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic               w_tick;
  logic [3:0]         w_code;
  logic [6:0]         w_seg;
  logic [3:0]         w_an;

  assign w_tick = (r_cnt == c_cnt_last);
  assign w_code = r_frame[{r_slot, 2'b00} +: 4];

  // Segment order {g,f,e,d,c,b,a}, active-low; code 10 is '-', 11..15 blank
  always_comb begin
    w_seg = 7'b1111111;
    case (w_code)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      4'd10:   w_seg = 7'b0111111;
      default: w_seg = 7'b1111111;
    endcase
  end

  always_comb begin
    w_an = 4'b1111;
    if (bus.en && (r_cnt >= c_blank)) begin
      w_an[r_slot] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_slot     <= 2'd0;
      r_frame    <= 16'hBBBB;
      r_dp_frame <= 4'b0000;
      r_an       <= 4'b1111;
      r_seg      <= 7'b1111111;
      r_dp       <= 1'b1;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_slot <= r_slot + 2'd1;
        // Latch only at the 3->0 wrap so one scan never mixes two words
        if (r_slot == 2'd3) begin
          r_frame    <= bus.Digit_in;
          r_dp_frame <= bus.dp_in;
        end
      end
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= ~r_dp_frame[r_slot];
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// Bench for seven_seg_scanner: cycle-number based reference model, per-cycle
// comparison, literal anchor points and a randomized phase.
module tb_seven_seg_scanner;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = 4 * RD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seven_seg_scanner_if bus();

  seven_seg_scanner #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: n = clock edges since reset release
  int          n;
  int          m_c;
  int          m_s;
  logic [15:0] m_frame;
  logic [3:0]  m_dpf;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at n=%0d: got {an,seg,dp}=%b required %b", name, n, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    check(name, {bus.an, bus.seg, bus.dp}, {an, seg, dp});
    check({name, "_model"}, {e_an, e_seg, e_dp}, {an, seg, dp});
  endtask

  task automatic wait_n(input int target);
    int guard;
    guard = 0;
    while (n < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (n != target) begin
      tests++;
      fails++;
      $display("FAIL wait_n: reached n=%0d required %0d", n, target);
    end
  endtask

  // Reference model: outputs after an edge reflect the state before it
  initial begin
    n = 0; m_frame = 16'hBBBB; m_dpf = 4'b0000;
    e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; m_frame = 16'hBBBB; m_dpf = 4'b0000;
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
      end else begin
        m_c   = n % RD;
        m_s   = (n / RD) % 4;
        e_an  = (!bus.en || m_c < BL) ? 4'b1111 : ~(4'b0001 << m_s);
        e_seg = seg_tab[m_frame[4*m_s +: 4]];
        e_dp  = ~m_dpf[m_s];
        if (n % FR == FR - 1) begin
          m_frame = bus.Digit_in;
          m_dpf   = bus.dp_in;
        end
        n++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cycle_out", {bus.an, bus.seg, bus.dp}, {e_an, e_seg, e_dp});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Digit_in = 16'hA123;
    bus.dp_in    = 4'b0000;
    bus.en       = 1'b1;
    repeat (3) @(negedge clk);
    lit("in_reset", 4'b1111, 7'b1111111, 1'b1);
    rst_n = 1'b1;

    wait_n(13); lit("first_frame_blank", 4'b1101, 7'b1111111, 1'b1);
    wait_n(34); lit("slot0_blanking",    4'b1111, 7'b0110000, 1'b1);
    wait_n(36); lit("slot0_digit3",      4'b1110, 7'b0110000, 1'b1);
    wait_n(44); lit("slot1_digit2",      4'b1101, 7'b0100100, 1'b1);
    bus.Digit_in = 16'hB456;
    wait_n(52); lit("tear_slot2_1",      4'b1011, 7'b1111001, 1'b1);
    wait_n(60); lit("tear_slot3_minus",  4'b0111, 7'b0111111, 1'b1);
    wait_n(68); lit("new_slot0_6",       4'b1110, 7'b0000010, 1'b1);
    wait_n(76); lit("new_slot1_5",       4'b1101, 7'b0010010, 1'b1);
    wait_n(84); lit("new_slot2_4",       4'b1011, 7'b0011001, 1'b1);
    wait_n(92); lit("new_slot3_blank",   4'b0111, 7'b1111111, 1'b1);

    wait_n(99); lit("before_en_off",     4'b1110, 7'b0000010, 1'b1);
    bus.en = 1'b0;
    wait_n(100); lit("en_off_gated",     4'b1111, 7'b0000010, 1'b1);
    wait_n(119);
    bus.en = 1'b1;
    wait_n(120); lit("en_back_slot2",    4'b1011, 7'b0011001, 1'b1);
    bus.dp_in = 4'b0100;

    wait_n(140); lit("dp_off_slot1",     4'b1101, 7'b0010010, 1'b1);
    wait_n(148); lit("dp_on_slot2",      4'b1011, 7'b0011001, 1'b0);
    wait_n(150);
    #2 rst_n = 1'b0;
    #1 lit("async_reset",                4'b1111, 7'b1111111, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_n(13); lit("after_reset_blank", 4'b1101, 7'b1111111, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)   bus.Digit_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0)  bus.dp_in    = 4'($urandom);
      if ($urandom_range(0, 15) == 0)  bus.en       = ~bus.en;
      if ($urandom_range(0, 599) == 0) begin
        #($urandom_range(1, 4)) rst_n = 1'b0;
        #1 check("rand_async_reset", {bus.an, bus.seg, bus.dp}, {4'b1111, 7'b1111111, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
